prog_counter: RTL

- Fetch-side program counter and next-PC stage; sits directly downstream of the ALU and consumes its zero flag to resolve conditional branches.
- Produces the instruction address each cycle.
- Uses a small writable branch-target lookup table so that 8-bit instructions need only carry a 4-bit target index.
- Includes a start/halt state machine that tells the testbench when the program has finished.

---
 rtl/prog_counter_pkg.sv | 21 ++
 rtl/prog_counter_branch_lut.sv | 34 +++
 rtl/prog_counter.sv | 101 ++++++++++
 3 files changed

// File: rtl/prog_counter_pkg.sv
// Shared definitions for the program-counter slice: FSM state type, default
// geometry and the LUT index-width helper.
package prog_counter_pkg;

  localparam int PC_WIDTH_DEF   = 10;
  localparam int LUT_DEPTH_DEF  = 16;
  localparam int START_ADDR_DEF = 0;
  localparam int CYCLE_CNT_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } pc_state_e;

  // A one-entry table still needs a one-bit index port.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prog_counter_branch_lut.sv
// Branch-target lookup table: cleared on reset, synchronous write, combinational
// read. Out-of-range indices read 0 and writes to them are dropped.
module branch_lut
  import prog_counter_pkg::*;
#(
  parameter int PC_WIDTH  = PC_WIDTH_DEF,
  parameter int LUT_DEPTH = LUT_DEPTH_DEF,
  parameter int IDX_W     = idx_width(LUT_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [PC_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]    raddr,
  output logic [PC_WIDTH-1:0] rdata
);

  logic [PC_WIDTH-1:0] mem [LUT_DEPTH];

  // NOTE: the table must read 0 after reset, so it is built from resettable
  // flops rather than a RAM macro; keep LUT_DEPTH small.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < LUT_DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-write contents, so a same-cycle write is visible next cycle.
  assign rdata = (int'(raddr) < LUT_DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/prog_counter.sv
// Fetch-side program counter with Idle/Run/Done control and a branch-target LUT.
// Optional Run-cycle counter enabled by defining PC_CYCLE_COUNT_EN.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int PC_WIDTH   = PC_WIDTH_DEF,
  parameter int LUT_DEPTH  = LUT_DEPTH_DEF,
  parameter int START_ADDR = START_ADDR_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_in,
  input  logic                               halt_in,
  input  logic                               stall_in,
  input  logic                               jump_in,
  input  logic                               branch_in,
  input  logic                               zero_in,
  input  logic [idx_width(LUT_DEPTH)-1:0]    lut_idx_in,
  input  logic                               lut_we_in,
  input  logic [idx_width(LUT_DEPTH)-1:0]    lut_waddr_in,
  input  logic [PC_WIDTH-1:0]                lut_wdata_in,
  output logic [PC_WIDTH-1:0]                pc_out,
  output logic                               running_out,
  output logic                               done_out
`ifdef PC_CYCLE_COUNT_EN
  ,
  output logic [CYCLE_CNT_W-1:0]             cycle_cnt_out
`endif
);

  localparam int IDX_W = idx_width(LUT_DEPTH);
  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);

  pc_state_e           state;
  logic [PC_WIDTH-1:0] lut_target;

  branch_lut #(
    .PC_WIDTH  (PC_WIDTH),
    .LUT_DEPTH (LUT_DEPTH),
    .IDX_W     (IDX_W)
  ) u_branch_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (lut_we_in),
    .waddr (lut_waddr_in),
    .wdata (lut_wdata_in),
    .raddr (lut_idx_in),
    .rdata (lut_target)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc_out      <= START_PC;
      running_out <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start_in) begin
            state       <= S_RUN;
            pc_out      <= START_PC;
            running_out <= 1'b1;
            done_out    <= 1'b0;
          end
        end
        S_RUN: begin
          if (halt_in) begin
            state       <= S_DONE;
            running_out <= 1'b0;
            done_out    <= 1'b1;
          end else if (!stall_in) begin
            if (jump_in || (branch_in && zero_in)) pc_out <= lut_target;
            else                                   pc_out <= pc_out + PC_WIDTH'(1);
          end
        end
        default: begin
          state       <= S_IDLE;
          running_out <= 1'b0;
          done_out    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_CYCLE_COUNT_EN
  // The halt cycle itself is not counted: it is the transition into Done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_out <= '0;
    end else if (start_in && (state == S_IDLE || state == S_DONE)) begin
      cycle_cnt_out <= '0;
    end else if (state == S_RUN && !halt_in && cycle_cnt_out != '1) begin
      cycle_cnt_out <= cycle_cnt_out + CYCLE_CNT_W'(1);
    end
  end
`endif

endmodule
